// File: rtl/c3lib_rst_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c3lib_rst_seq_pkg
// Description : Shared types and helpers for the reset sequencer
//               (c3lib_rst_seq_ctrl). Holds the sequencer state encoding,
//               the err_stage width helper and the default ack timeout.
//               Optional feature macro used by the sequencer:
//               C3LIB_RST_SEQ_ACK_MON_EN
// Revision    : 1.0 - initial release
// ============================================================================
package c3lib_rst_seq_pkg;

    // Sequencer states, fixed encoding so status taps stay stable across builds
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RELEASE  = 3'd1,
        ST_WAIT_ACK = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } seq_state_e;

    // Default number of WAIT_ACK cycles tolerated before flagging an error
    localparam int c_default_timeout = 64;

    // Width of a domain index; never narrower than one bit
    function automatic int err_w(input int num_stages);
        return (num_stages > 1) ? $clog2(num_stages) : 1;
    endfunction

endpackage : c3lib_rst_seq_pkg
`default_nettype wire

// File: rtl/c3lib_rst_seq_ack_sync.sv
`default_nettype none
// ============================================================================
// Module      : c3lib_rst_seq_ack_sync
// Description : Multi-bit flop-chain synchronizer for the per-domain
//               asynchronous acks. Each bit is an independent level, so a
//               plain SYNC_STAGES-deep chain per bit is sufficient. All flops
//               clear to 0 on the synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module c3lib_rst_seq_ack_sync #(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] i_ack_async,
    output logic [NUM_STAGES-1:0] o_ack_sync
);

    // Chain element 0 is the capture flop, element SYNC_STAGES-1 the output
    logic [SYNC_STAGES-1:0][NUM_STAGES-1:0] r_sync;

    // Shift the raw acks through the chain; the whole chain clears on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_ack_async};
        end
    end

    assign o_ack_sync = r_sync[SYNC_STAGES-1];

endmodule : c3lib_rst_seq_ack_sync
`default_nettype wire

// File: rtl/c3lib_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : c3lib_rst_seq_ctrl
// Description : Releases NUM_STAGES active-low domain resets one at a time.
//               After each release the domain's synchronized ack is awaited
//               (bounded by TIMEOUT), then cfg_settle extra cycles elapse
//               before the next domain is released. seq_abort or rst puts
//               every domain back into reset.
//               Optional feature macro: C3LIB_RST_SEQ_ACK_MON_EN - when
//               defined, acks of already accepted domains are monitored in
//               SETTLE and DONE and a drop is reported as an error.
// Revision    : 1.0 - initial release
// ============================================================================
module c3lib_rst_seq_ctrl
    import c3lib_rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 3,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = c_default_timeout
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              seq_start,
    input  logic                              seq_abort,
    input  logic [CNT_W-1:0]                  cfg_settle,
    input  logic [NUM_STAGES-1:0]             stage_ack,
    output logic [NUM_STAGES-1:0]             stage_rst_n,
    output logic                              seq_done,
    output logic                              seq_err,
    output logic [err_w(NUM_STAGES)-1:0]      err_stage
);

    localparam int IDX_W = err_w(NUM_STAGES);

    localparam logic [CNT_W-1:0] c_cnt_max      = '1;
    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] c_last_idx     = IDX_W'(NUM_STAGES - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    seq_state_e            r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_seq_done;
    logic                  r_seq_err;
    logic [IDX_W-1:0]      r_err_stage;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    seq_state_e            w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [NUM_STAGES-1:0] w_stage_rst_n_nxt;
    logic                  w_seq_done_nxt;
    logic                  w_seq_err_nxt;
    logic [IDX_W-1:0]      w_err_stage_nxt;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] w_ack_s;
    logic [NUM_STAGES-1:0] w_idx_onehot;
    logic [CNT_W-1:0]      w_cnt_inc;
    logic                  w_ack_cur;

    c3lib_rst_seq_ack_sync #(
        .NUM_STAGES  (NUM_STAGES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk         (clk),
        .rst         (rst),
        .i_ack_async (stage_ack),
        .o_ack_sync  (w_ack_s)
    );

    assign w_idx_onehot = NUM_STAGES'(1) << r_idx;
    assign w_ack_cur    = |(w_ack_s & w_idx_onehot);
    // The counter sticks at all-ones instead of wrapping back to zero
    assign w_cnt_inc    = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef C3LIB_RST_SEQ_ACK_MON_EN
    // ------------------------------------------------------------------
    // Lost-ack monitor: domains below idx (SETTLE) or all domains (DONE)
    // must keep their ack high once it has been accepted.
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0] w_mon_mask;
    logic [NUM_STAGES-1:0] w_ack_lost;
    logic                  w_lost_any;
    logic [IDX_W-1:0]      w_lost_idx;

    // Select which synchronized acks are being watched and pick the lowest loss
    always_comb begin
        w_mon_mask = '0;
        w_lost_idx = '0;
        if (r_state == ST_SETTLE) begin
            w_mon_mask = w_idx_onehot - NUM_STAGES'(1);
        end else if (r_state == ST_DONE) begin
            w_mon_mask = '1;
        end
        w_ack_lost = w_mon_mask & ~w_ack_s;
        w_lost_any = |w_ack_lost;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            if (w_ack_lost[j]) begin
                w_lost_idx = IDX_W'(j);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Register every piece of sequencer state; rst returns to IDLE
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_stage_rst_n <= '0;
            r_seq_done    <= 1'b0;
            r_seq_err     <= 1'b0;
            r_err_stage   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_stage_rst_n <= w_stage_rst_n_nxt;
            r_seq_done    <= w_seq_done_nxt;
            r_seq_err     <= w_seq_err_nxt;
            r_err_stage   <= w_err_stage_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode; abort overrides every state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_cnt_nxt         = r_cnt;
        w_stage_rst_n_nxt = r_stage_rst_n;
        w_seq_done_nxt    = r_seq_done;
        w_seq_err_nxt     = r_seq_err;
        w_err_stage_nxt   = r_err_stage;

        if (seq_abort) begin
            w_state_nxt       = ST_IDLE;
            w_idx_nxt         = '0;
            w_cnt_nxt         = '0;
            w_stage_rst_n_nxt = '0;
            w_seq_done_nxt    = 1'b0;
            w_seq_err_nxt     = 1'b0;
            w_err_stage_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (seq_start) begin
                        w_state_nxt = ST_RELEASE;
                        w_idx_nxt   = '0;
                        w_cnt_nxt   = '0;
                    end
                end

                ST_RELEASE: begin
                    // Earlier domains stay released; only bit idx is added
                    w_stage_rst_n_nxt = r_stage_rst_n | w_idx_onehot;
                    w_cnt_nxt         = '0;
                    w_state_nxt       = ST_WAIT_ACK;
                end

                ST_WAIT_ACK: begin
                    // An ack seen on the final timeout cycle still wins
                    if (w_ack_cur) begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= c_timeout_last) begin
                        w_state_nxt       = ST_ERR;
                        w_seq_err_nxt     = 1'b1;
                        w_err_stage_nxt   = r_idx;
                        w_stage_rst_n_nxt = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                ST_SETTLE: begin
`ifdef C3LIB_RST_SEQ_ACK_MON_EN
                    if (w_lost_any) begin
                        w_state_nxt       = ST_ERR;
                        w_seq_err_nxt     = 1'b1;
                        w_err_stage_nxt   = w_lost_idx;
                        w_stage_rst_n_nxt = '0;
                    end else
`endif
                    if (r_cnt >= cfg_settle) begin
                        if (r_idx == c_last_idx) begin
                            w_state_nxt    = ST_DONE;
                            w_seq_done_nxt = 1'b1;
                        end else begin
                            w_idx_nxt   = r_idx + IDX_W'(1);
                            w_cnt_nxt   = '0;
                            w_state_nxt = ST_RELEASE;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end

                ST_DONE: begin
`ifdef C3LIB_RST_SEQ_ACK_MON_EN
                    if (w_lost_any) begin
                        w_state_nxt       = ST_ERR;
                        w_seq_err_nxt     = 1'b1;
                        w_seq_done_nxt    = 1'b0;
                        w_err_stage_nxt   = w_lost_idx;
                        w_stage_rst_n_nxt = '0;
                    end
`endif
                end

                ST_ERR: begin
                    // Parked until abort or reset
                end

                default: begin
                    w_state_nxt       = ST_IDLE;
                    w_idx_nxt         = '0;
                    w_cnt_nxt         = '0;
                    w_stage_rst_n_nxt = '0;
                    w_seq_done_nxt    = 1'b0;
                    w_seq_err_nxt     = 1'b0;
                    w_err_stage_nxt   = '0;
                end
            endcase
        end
    end

    assign stage_rst_n = r_stage_rst_n;
    assign seq_done    = r_seq_done;
    assign seq_err     = r_seq_err;
    assign err_stage   = r_err_stage;

endmodule : c3lib_rst_seq_ctrl
`default_nettype wire

// File: tb/tb_c3lib_rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_c3lib_rst_seq_ctrl
// Description : Directed self-checking bench for c3lib_rst_seq_ctrl with the
//               default parameters (4 domains, 3-flop sync, 8-bit counters,
//               timeout 64). Ack-monitor expectations follow the
//               C3LIB_RST_SEQ_ACK_MON_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c3lib_rst_seq_ctrl;

    localparam int N     = 4;
    localparam int CW    = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          seq_start;
    logic          seq_abort;
    logic [CW-1:0] cfg_settle;
    logic [N-1:0]  stage_ack;
    logic [N-1:0]  stage_rst_n;
    logic          seq_done;
    logic          seq_err;
    logic [1:0]    err_stage;

    int checks = 0;
    int errors = 0;

    c3lib_rst_seq_ctrl #(
        .NUM_STAGES  (4),
        .SYNC_STAGES (3),
        .CNT_W       (8),
        .TIMEOUT     (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seq_start   (seq_start),
        .seq_abort   (seq_abort),
        .cfg_settle  (cfg_settle),
        .stage_ack   (stage_ack),
        .stage_rst_n (stage_rst_n),
        .seq_done    (seq_done),
        .seq_err     (seq_err),
        .err_stage   (err_stage)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse seq_start for one edge (the RELEASE edge)
    task automatic pulse_start();
        seq_start = 1'b1;
        tick();
        seq_start = 1'b0;
    endtask

    // Abort, drop acks and let the synchronizer drain
    task automatic abort_and_clear();
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        stage_ack = '0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; seq_start = 1'b0; seq_abort = 1'b0;
        cfg_settle = '0; stage_ack = '0;
        repeat (3) tick();
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL reset_rst_n: got %b expected 0000", stage_rst_n); end
        checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", seq_done); end
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", seq_err); end
        checks++; if (err_stage !== 2'd0) begin errors++; $display("FAIL reset_err_stage: got %0d expected 0", err_stage); end
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL idle_hold: got %b expected 0000", stage_rst_n); end
    endtask

    // Ack 5 cycles after each release, settle 2: releases 13 cycles apart
    task automatic test_happy_path();
        logic [N-1:0] exp;
        cfg_settle = 8'd2;
        pulse_start();
        tick();
        exp = 4'b0001;
        checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL happy_first: got %b expected %b", stage_rst_n, exp); end
        for (int i = 0; i < N; i++) begin
            repeat (5) tick();
            stage_ack[i] = 1'b1;
            if (i < N - 1) begin
                repeat (7) tick();
                checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL happy_early_%0d: got %b expected %b", i, stage_rst_n, exp); end
                tick();
                exp = exp | (4'b0001 << (i + 1));
                checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL happy_release_%0d: got %b expected %b", i + 1, stage_rst_n, exp); end
            end else begin
                repeat (6) tick();
                checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL happy_done_early: got %b expected 0", seq_done); end
                tick();
                checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL happy_done: got %b expected 1", seq_done); end
                checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL happy_err: got %b expected 0", seq_err); end
                checks++; if (stage_rst_n !== 4'b1111) begin errors++; $display("FAIL happy_all: got %b expected 1111", stage_rst_n); end
            end
        end
        // seq_start in DONE is ignored
        seq_start = 1'b1;
        repeat (3) tick();
        seq_start = 1'b0;
        checks++; if (seq_done !== 1'b1 || stage_rst_n !== 4'b1111) begin errors++; $display("FAIL done_hold: got done=%b rst_n=%b expected 1 1111", seq_done, stage_rst_n); end
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        checks++; if (stage_rst_n !== 4'b0000 || seq_done !== 1'b0) begin errors++; $display("FAIL happy_abort: got rst_n=%b done=%b expected 0000 0", stage_rst_n, seq_done); end
        stage_ack = '0;
        repeat (4) tick();
    endtask

    // Stage 2 never acks: error 64 cycles after its WAIT_ACK entry
    task automatic test_timeout();
        cfg_settle = 8'd0;
        stage_ack  = 4'b0011;
        repeat (4) tick();
        pulse_start();
        tick();
        checks++; if (stage_rst_n !== 4'b0001) begin errors++; $display("FAIL to_rel0: got %b expected 0001", stage_rst_n); end
        repeat (3) tick();
        checks++; if (stage_rst_n !== 4'b0011) begin errors++; $display("FAIL to_rel1: got %b expected 0011", stage_rst_n); end
        repeat (3) tick();
        checks++; if (stage_rst_n !== 4'b0111) begin errors++; $display("FAIL to_rel2: got %b expected 0111", stage_rst_n); end
        repeat (63) tick();
        checks++; if (seq_err !== 1'b0 || stage_rst_n !== 4'b0111) begin errors++; $display("FAIL to_early: got err=%b rst_n=%b expected 0 0111", seq_err, stage_rst_n); end
        tick();
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b expected 1", seq_err); end
        checks++; if (err_stage !== 2'd2) begin errors++; $display("FAIL to_err_stage: got %0d expected 2", err_stage); end
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL to_rst_n: got %b expected 0000", stage_rst_n); end
        // ERR ignores seq_start
        seq_start = 1'b1;
        repeat (3) tick();
        seq_start = 1'b0;
        checks++; if (seq_err !== 1'b1 || stage_rst_n !== 4'b0000) begin errors++; $display("FAIL to_hold: got err=%b rst_n=%b expected 1 0000", seq_err, stage_rst_n); end
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        checks++; if (seq_err !== 1'b0 || err_stage !== 2'd0) begin errors++; $display("FAIL to_abort: got err=%b stage=%0d expected 0 0", seq_err, err_stage); end
        stage_ack = '0;
        repeat (4) tick();
    endtask

    // Abort and start together in stage-1 WAIT_ACK: abort wins
    task automatic test_abort_priority();
        cfg_settle = 8'd0;
        stage_ack  = 4'b0001;
        repeat (4) tick();
        pulse_start();
        tick();
        repeat (3) tick();
        checks++; if (stage_rst_n !== 4'b0011) begin errors++; $display("FAIL ab_rel1: got %b expected 0011", stage_rst_n); end
        repeat (2) tick();
        seq_abort = 1'b1;
        seq_start = 1'b1;
        tick();
        seq_abort = 1'b0;
        seq_start = 1'b0;
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL ab_now: got %b expected 0000", stage_rst_n); end
        repeat (4) tick();
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL ab_idle: got %b expected 0000", stage_rst_n); end
        pulse_start();
        tick();
        checks++; if (stage_rst_n !== 4'b0001) begin errors++; $display("FAIL ab_restart: got %b expected 0001", stage_rst_n); end
        abort_and_clear();
    endtask

    // Settle 0 with pre-high acks: 3-cycle spacing; ack on timeout cycle wins
    task automatic test_boundaries();
        logic [N-1:0] exp;
        cfg_settle = 8'd0;
        stage_ack  = 4'b1111;
        repeat (4) tick();
        pulse_start();
        tick();
        exp = 4'b0001;
        checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL bd_rel0: got %b expected %b", stage_rst_n, exp); end
        for (int i = 1; i < N; i++) begin
            repeat (2) tick();
            checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL bd_early_%0d: got %b expected %b", i, stage_rst_n, exp); end
            tick();
            exp = exp | (4'b0001 << i);
            checks++; if (stage_rst_n !== exp) begin errors++; $display("FAIL bd_rel_%0d: got %b expected %b", i, stage_rst_n, exp); end
        end
        repeat (2) tick();
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL bd_done: got %b expected 1", seq_done); end
        seq_abort = 1'b1;
        tick();
        seq_abort = 1'b0;
        stage_ack = 4'b0001;
        repeat (4) tick();
        pulse_start();
        repeat (4) tick();
        checks++; if (stage_rst_n !== 4'b0011) begin errors++; $display("FAIL bd_tc_rel1: got %b expected 0011", stage_rst_n); end
        repeat (60) tick();
        stage_ack[1] = 1'b1;
        repeat (4) tick();
        checks++; if (seq_err !== 1'b0 || stage_rst_n !== 4'b0011) begin errors++; $display("FAIL bd_tc_noerr: got err=%b rst_n=%b expected 0 0011", seq_err, stage_rst_n); end
        repeat (2) tick();
        checks++; if (stage_rst_n !== 4'b0111) begin errors++; $display("FAIL bd_tc_next: got %b expected 0111", stage_rst_n); end
        abort_and_clear();
    endtask

    // rst during stage-3 SETTLE clears everything including sync flops
    task automatic test_mid_rst();
        cfg_settle = 8'd10;
        stage_ack  = 4'b1111;
        repeat (4) tick();
        pulse_start();
        tick();
        checks++; if (stage_rst_n !== 4'b0001) begin errors++; $display("FAIL mr_rel0: got %b expected 0001", stage_rst_n); end
        repeat (39) tick();
        checks++; if (stage_rst_n !== 4'b1111 || seq_done !== 1'b0) begin errors++; $display("FAIL mr_rel3: got rst_n=%b done=%b expected 1111 0", stage_rst_n, seq_done); end
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL mr_rst_n: got %b expected 0000", stage_rst_n); end
        checks++; if (seq_done !== 1'b0 || seq_err !== 1'b0 || err_stage !== 2'd0) begin errors++; $display("FAIL mr_flags: got done=%b err=%b stage=%0d expected 0 0 0", seq_done, seq_err, err_stage); end
        checks++; if (dut.w_ack_s !== 4'b0000) begin errors++; $display("FAIL mr_sync: got %b expected 0000", dut.w_ack_s); end
        tick();
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL mr_idle: got %b expected 0000", stage_rst_n); end
        stage_ack = '0;
        repeat (4) tick();
    endtask

    // Drop ack 1 after seq_done
    task automatic test_ack_mon();
        cfg_settle = 8'd0;
        stage_ack  = 4'b1111;
        repeat (4) tick();
        pulse_start();
        repeat (12) tick();
        checks++; if (seq_done !== 1'b1) begin errors++; $display("FAIL am_done: got %b expected 1", seq_done); end
        stage_ack[1] = 1'b0;
`ifdef C3LIB_RST_SEQ_ACK_MON_EN
        repeat (3) tick();
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL am_early: got %b expected 0", seq_err); end
        tick();
        checks++; if (seq_err !== 1'b1 || err_stage !== 2'd1) begin errors++; $display("FAIL am_err: got err=%b stage=%0d expected 1 1", seq_err, err_stage); end
        checks++; if (stage_rst_n !== 4'b0000) begin errors++; $display("FAIL am_rst_n: got %b expected 0000", stage_rst_n); end
`else
        repeat (6) tick();
        checks++; if (seq_done !== 1'b1 || seq_err !== 1'b0) begin errors++; $display("FAIL am_nomon: got done=%b err=%b expected 1 0", seq_done, seq_err); end
        checks++; if (stage_rst_n !== 4'b1111) begin errors++; $display("FAIL am_nomon_rst_n: got %b expected 1111", stage_rst_n); end
`endif
        abort_and_clear();
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_timeout();
        test_abort_priority();
        test_boundaries();
        test_mid_rst();
        test_ack_mon();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_c3lib_rst_seq_ctrl
`default_nettype wire
